ps2_mouse_init_ctrl: RTL and testbench
======================================

Name: ps2_mouse_init_ctrl

Overview:
Host-side PS/2 sequencer that brings the mouse from power-up into streaming mode, then hands the bus to the existing packet receiver.
- Reset/enable sequence: sends Reset (0xFF), checks ACK (0xFA), BAT (0xAA) and ID (0x00), sends Enable Data Reporting (0xF4), checks ACK.
- Then asserts enable_send to the receiver.
- Owns the open-drain drive of ps2_clk/ps2_data; retries failed sequences and flags permanent failure.

Parameters:
INHIBIT_CYCLES, 5000, clk cycles ps2_clk is held low before a host transmit (100 us at 50 MHz)
RESP_TIMEOUT, 25000000, clk cycles allowed for any device byte or host-send completion (500 ms)
MAX_RETRY, 3, full-sequence retries before declaring error
SAMPLE_RATE, 8'd100, rate byte sent when SAMPLE_RATE_EN is defined

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse; begins or restarts the init sequence
ps2_clk_in  in  1  raw PS/2 clock line level
ps2_data_in  in  1  raw PS/2 data line level
ps2_clk_oe  out  1  1 = drive PS/2 clock low, 0 = release
ps2_data_oe  out  1  1 = drive PS/2 data low, 0 = release
enable_send  out  1  receiver enable; high only in STREAM
init_done  out  1  high in STREAM
init_error  out  1  high in ERROR
retry_count  out  2  retries used in the current attempt
state_dbg  out  4  current main FSM state encoding

Behaviour:
Reset values: all outputs 0; FSM = IDLE; shift regs, counters, timers cleared.

Line sampling and edge detect:
- ps2_clk_in/ps2_data_in pass through 2-flop synchronizers.
- Falling edge = synced clk was 1 and is now 0. One edge event per device clock.

Host send sub-FSM (TX_INHIBIT, TX_START, TX_BITS, TX_ACK):
- TX_INHIBIT: clk_oe=1 for INHIBIT_CYCLES.
- TX_START: data_oe=1 (start bit = 0); next cycle clk_oe=0.
- TX_BITS: on each falling edge, present the next bit. Order: D0..D7 LSB first, then odd parity, then stop = release data_oe.
  - data_oe = ~bit.
  - Parity = ~^byte.
- TX_ACK: on the next falling edge sample data. Data 0 = send ok; data 1 = send fail.

Receive sub-FSM:
- Shifts 11 bits on falling edges: start, D0..D7, parity, stop.
- Byte valid iff start=0, stop=1 and odd parity holds.
- Bit counter and timer clear on entry to each wait state.

Main FSM:
- IDLE: waits for start.
- SEND_FF → WAIT_FA → WAIT_AA → WAIT_00 → SEND_F4 → WAIT_FA2 → STREAM.
- Each wait state compares the received byte with its expected value.
- Each SEND/WAIT state runs its own RESP_TIMEOUT counter.

Failure handling:
- Failure = timeout, send fail, framing/parity error, or unexpected byte.
- On failure: if retry_count < MAX_RETRY, increment retry_count, release both lines, go to SEND_FF.
- Otherwise go to ERROR.

STREAM:
- enable_send=1, init_done=1, both lines released.
- Stays in STREAM until reset or start.

ERROR:
- init_error=1, both lines released.
- Stays in ERROR until reset or start.

start in any state other than IDLE:
- Abort; release both lines; enable_send=0 the same cycle; clear retry_count; go to SEND_FF next cycle.

Other rules:
- reset mid-transfer releases both lines on the next edge.
- enable_send deasserts in the same cycle the FSM leaves STREAM.
- ps2_clk_oe and ps2_data_oe are never asserted outside SEND states.
- Received data is ignored outside WAIT states.

Optional Feature:
SAMPLE_RATE_EN:
- Defined: between WAIT_00 and SEND_F4, insert SEND_F3 → WAIT_FA_R → SEND_RATE (SAMPLE_RATE) → WAIT_FA_R2, with the same ACK, timeout and retry rules.
- Undefined: the sequence goes WAIT_00 → SEND_F4 directly. Those states and their encodings are absent.

Test Plan:
- Compliant mouse model; start pulse → host frame FF with parity 1 (clock held low ≥ 5000 cycles); model replies FA, AA, 00; host sends F4 with parity 0; model replies FA → enable_send=1, init_done=1, retry_count=0.
- Model replies FE instead of FA to FF → retry_count=1, sequence restarts with FF; second attempt compliant → STREAM.
- Model silent → timeout after each of 4 attempts → init_error=1, retry_count=3, both oe=0, enable_send=0.
- BAT byte AA with bad parity → treated as a failure and retried; correct AA on retry → STREAM.
- Reset asserted mid-TX_BITS → the next cycle shows ps2_clk_oe=0, ps2_data_oe=0, state_dbg=IDLE; start pulse during STREAM → enable_send drops the same cycle and FF is resent.
- With SAMPLE_RATE_EN defined → host sends F3 then 64; model ACKs both → F4 is sent, then STREAM.

Source files
------------

// File: rtl/ps2_mouse_init_ctrl.sv
// ps2_mouse_init_ctrl: host-side PS/2 mouse bring-up sequencer.
// Sends Reset (FF) and checks ACK/BAT/ID (FA, AA, 00), then sends Enable
// Data Reporting (F4) and checks its ACK. When that ACK arrives, the block
// hands the bus to the packet receiver through enable_send.
// Any failure retries the whole sequence, up to MAX_RETRY times, and after
// that the block parks in ERROR.
// Optional macro SAMPLE_RATE_EN: inserts F3 + SAMPLE_RATE (each ACKed)
// between the ID check and F4.
module ps2_mouse_init_ctrl #(
  parameter int         INHIBIT_CYCLES = 5000,
  parameter int         RESP_TIMEOUT   = 25000000,
  parameter int         MAX_RETRY      = 3,
  parameter logic [7:0] SAMPLE_RATE    = 8'd100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       enable_send,
  output logic       init_done,
  output logic       init_error,
  output logic [1:0] retry_count,
  output logic [3:0] state_dbg
);

  // One timer serves both the inhibit hold and the response timeout.
  // It assumes RESP_TIMEOUT > INHIBIT_CYCLES.
  localparam int TIMER_W = $clog2(RESP_TIMEOUT + 1);
  localparam logic [TIMER_W-1:0] INHIBIT_LAST = TIMER_W'(INHIBIT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] RESP_LAST    = TIMER_W'(RESP_TIMEOUT - 1);
  localparam logic [1:0]         RETRY_LIMIT  = 2'(MAX_RETRY);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    SEND_FF    = 4'd1,
    WAIT_FA    = 4'd2,
    WAIT_AA    = 4'd3,
    WAIT_00    = 4'd4,
    SEND_F4    = 4'd5,
    WAIT_FA2   = 4'd6,
    STREAM     = 4'd7,
    ERROR      = 4'd8
`ifdef SAMPLE_RATE_EN
    ,
    SEND_F3    = 4'd9,
    WAIT_FA_R  = 4'd10,
    SEND_RATE  = 4'd11,
    WAIT_FA_R2 = 4'd12
`endif
  } state_t;

  typedef enum logic [1:0] {
    TX_INHIBIT = 2'd0,
    TX_START   = 2'd1,
    TX_BITS    = 2'd2,
    TX_ACK     = 2'd3
  } tx_phase_t;

  logic clk_meta, clk_sync, clk_sync_d;
  logic data_meta, data_sync;
  logic fall;

  state_t              state_reg, state_next, after_state;
  tx_phase_t           tx_phase_reg, tx_phase_next;
  logic [TIMER_W-1:0]  timer_reg, timer_next;
  logic [3:0]          bit_cnt_reg, bit_cnt_next;
  logic                tx_bit_reg, tx_bit_next;
  logic [9:0]          rx_shift_reg, rx_shift_next;
  logic [1:0]          retry_reg, retry_next;

  logic       is_send, is_wait;
  logic [7:0] send_byte, expect_byte;
  logic [9:0] tx_frame;
  logic [10:0] rx_frame;
  logic       advance, fail, reload;

  // Two-flop synchronizers on both raw lines plus a delayed clock copy for edge detect.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_meta   <= 1'b0;
      clk_sync   <= 1'b0;
      clk_sync_d <= 1'b0;
      data_meta  <= 1'b0;
      data_sync  <= 1'b0;
    end else begin
      clk_meta   <= ps2_clk_in;
      clk_sync   <= clk_meta;
      clk_sync_d <= clk_sync;
      data_meta  <= ps2_data_in;
      data_sync  <= data_meta;
    end
  end

  assign fall = clk_sync_d & ~clk_sync;

  // State register for the main FSM and its transmit/receive bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      tx_phase_reg <= TX_INHIBIT;
      timer_reg    <= '0;
      bit_cnt_reg  <= '0;
      tx_bit_reg   <= 1'b0;
      rx_shift_reg <= '0;
      retry_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      tx_phase_reg <= tx_phase_next;
      timer_reg    <= timer_next;
      bit_cnt_reg  <= bit_cnt_next;
      tx_bit_reg   <= tx_bit_next;
      rx_shift_reg <= rx_shift_next;
      retry_reg    <= retry_next;
    end
  end

  // Per-state decode: which byte to send or expect, and where success leads.
  always_comb begin
    is_send     = 1'b0;
    is_wait     = 1'b0;
    // The rate byte is the fallback; only SEND_RATE ever transmits it.
    send_byte   = SAMPLE_RATE;
    expect_byte = 8'hFA;
    after_state = state_reg;
    case (state_reg)
      SEND_FF:    begin is_send = 1'b1; send_byte = 8'hFF; after_state = WAIT_FA; end
      WAIT_FA:    begin is_wait = 1'b1; expect_byte = 8'hFA; after_state = WAIT_AA; end
      WAIT_AA:    begin is_wait = 1'b1; expect_byte = 8'hAA; after_state = WAIT_00; end
`ifdef SAMPLE_RATE_EN
      WAIT_00:    begin is_wait = 1'b1; expect_byte = 8'h00; after_state = SEND_F3; end
      SEND_F3:    begin is_send = 1'b1; send_byte = 8'hF3; after_state = WAIT_FA_R; end
      WAIT_FA_R:  begin is_wait = 1'b1; expect_byte = 8'hFA; after_state = SEND_RATE; end
      SEND_RATE:  begin is_send = 1'b1; after_state = WAIT_FA_R2; end
      WAIT_FA_R2: begin is_wait = 1'b1; expect_byte = 8'hFA; after_state = SEND_F4; end
`else
      WAIT_00:    begin is_wait = 1'b1; expect_byte = 8'h00; after_state = SEND_F4; end
`endif
      SEND_F4:    begin is_send = 1'b1; send_byte = 8'hF4; after_state = WAIT_FA2; end
      WAIT_FA2:   begin is_wait = 1'b1; expect_byte = 8'hFA; after_state = STREAM; end
      default:    ;
    endcase
  end

  // Host frame as presented after each device falling edge: D0..D7, odd parity, stop.
  assign tx_frame = {1'b1, ~^send_byte, send_byte};
  // Receive frame once the current data bit is shifted in: start, D0..D7, parity, stop.
  assign rx_frame = {data_sync, rx_shift_reg};

  // Next-state logic: transmit phases, receive shifting, timeout and retry policy.
  always_comb begin
    state_next    = state_reg;
    tx_phase_next = tx_phase_reg;
    timer_next    = timer_reg;
    bit_cnt_next  = bit_cnt_reg;
    tx_bit_next   = tx_bit_reg;
    rx_shift_next = rx_shift_reg;
    retry_next    = retry_reg;
    advance       = 1'b0;
    fail          = 1'b0;
    reload        = 1'b0;

    if (is_send) begin
      case (tx_phase_reg)
        TX_INHIBIT: if (timer_reg == INHIBIT_LAST) begin
          tx_phase_next = TX_START;
          tx_bit_next   = 1'b0;
        end
        TX_START: tx_phase_next = TX_BITS;
        TX_BITS: if (fall) begin
          tx_bit_next = tx_frame[bit_cnt_reg];
          if (bit_cnt_reg == 4'd9) tx_phase_next = TX_ACK;
          else bit_cnt_next = bit_cnt_reg + 4'd1;
        end
        TX_ACK: if (fall) begin
          if (!data_sync) advance = 1'b1;
          else fail = 1'b1;
        end
        default: ;
      endcase
    end

    if (is_wait && fall) begin
      rx_shift_next = rx_frame[10:1];
      if (bit_cnt_reg == 4'd10) begin
        if (!rx_frame[0] && rx_frame[10] && (^rx_frame[9:1]) && (rx_frame[8:1] == expect_byte))
          advance = 1'b1;
        else
          fail = 1'b1;
      end else begin
        bit_cnt_next = bit_cnt_reg + 4'd1;
      end
    end

    // A byte completing on the last allowed cycle still counts as on time.
    if (is_send || is_wait) begin
      timer_next = timer_reg + TIMER_W'(1);
      if (timer_reg == RESP_LAST && !advance) fail = 1'b1;
    end

    if (start) begin
      state_next = SEND_FF;
      retry_next = '0;
      reload     = 1'b1;
    end else if (advance) begin
      state_next = after_state;
      reload     = 1'b1;
    end else if (fail) begin
      if (retry_reg < RETRY_LIMIT) begin
        retry_next = retry_reg + 2'd1;
        state_next = SEND_FF;
      end else begin
        state_next = ERROR;
      end
      reload = 1'b1;
    end

    // Every entry into a SEND/WAIT state starts with fresh counters and a released data line.
    if (reload) begin
      tx_phase_next = TX_INHIBIT;
      timer_next    = '0;
      bit_cnt_next  = '0;
      tx_bit_next   = 1'b1;
      rx_shift_next = '0;
    end
  end

  // Line drivers and status; start and failures release the lines in the same cycle.
  always_comb begin
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    if (is_send && !start && !fail) begin
      ps2_clk_oe  = (tx_phase_reg == TX_INHIBIT) || (tx_phase_reg == TX_START);
      ps2_data_oe = ((tx_phase_reg == TX_START) || (tx_phase_reg == TX_BITS)) && !tx_bit_reg;
    end
    enable_send = (state_reg == STREAM) && !start;
    init_done   = (state_reg == STREAM);
    init_error  = (state_reg == ERROR);
    retry_count = retry_reg;
    state_dbg   = state_reg;
  end

endmodule

// File: tb/tb_ps2_mouse_init_ctrl.sv
// tb_ps2_mouse_init_ctrl: directed bench with a behavioural PS/2 mouse.
// Expected host bytes are queued when a sequence is launched and popped as
// the mouse model clocks each host frame in.
module tb_ps2_mouse_init_ctrl;

  localparam int INH  = 40;
  localparam int RT   = 3000;
  localparam int HALF = 20;
  localparam int QTR  = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;
  logic ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic enable_send, init_done, init_error;
  logic [1:0] retry_count;
  logic [3:0] state_dbg;

  int checks = 0;
  int failures = 0;
  int inh_run = 0;
  int last_inhibit = 0;
  logic [7:0] tx_q[$];

  always #5 clk = ~clk;

  // Open-drain bus: either side can pull a line low.
  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_mouse_init_ctrl #(
    .INHIBIT_CYCLES(INH),
    .RESP_TIMEOUT(RT),
    .MAX_RETRY(3),
    .SAMPLE_RATE(8'd100)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .ps2_clk_in(ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .enable_send(enable_send),
    .init_done(init_done),
    .init_error(init_error),
    .retry_count(retry_count),
    .state_dbg(state_dbg)
  );

  // Length of the most recent completed clock-inhibit run.
  always @(negedge clk) begin
    if (ps2_clk_oe) begin
      inh_run <= inh_run + 1;
    end else begin
      if (inh_run != 0) last_inhibit <= inh_run;
      inh_run <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic en, input logic done,
                              input logic err, input logic [1:0] rc);
    check({tag, "_enable_send"}, enable_send, en);
    check({tag, "_init_done"}, init_done, done);
    check({tag, "_init_error"}, init_error, err);
    check({tag, "_retry_count"}, retry_count, rc);
    check({tag, "_clk_oe"}, ps2_clk_oe, 1'b0);
    check({tag, "_data_oe"}, ps2_data_oe, 1'b0);
  endtask

  // Mouse side of a host-to-device transfer; compares against the scoreboard.
  task automatic host_frame();
    int n;
    logic [9:0] bits;
    logic [7:0] exp_b;
    n = 0;
    while (ps2_clk_oe !== 1'b1 && n < 4 * RT) begin tick(1); n++; end
    check("inhibit_start", ps2_clk_oe, 1'b1);
    n = 0;
    while (ps2_clk_oe === 1'b1 && n < 4 * RT) begin tick(1); n++; end
    check("clk_release", ps2_clk_oe, 1'b0);
    check("start_bit", ps2_data_oe, 1'b1);
    tick(10);
    check("inhibit_len", last_inhibit, INH + 1);
    bits = '0;
    for (int i = 0; i < 10; i++) begin
      dev_clk_low = 1'b1;
      tick(HALF);
      dev_clk_low = 1'b0;
      tick(2 * QTR);
      bits[i] = ps2_data_in;
      tick(HALF - 2 * QTR);
    end
    dev_data_low = 1'b1;
    tick(QTR);
    dev_clk_low = 1'b1;
    tick(HALF);
    dev_clk_low = 1'b0;
    tick(HALF);
    dev_data_low = 1'b0;
    check("sb_pending", (tx_q.size() != 0), 1'b1);
    exp_b = (tx_q.size() != 0) ? tx_q.pop_front() : 8'h00;
    $display("host frame byte=%02h parity=%0d stop=%0d expected_byte=%02h",
             bits[7:0], bits[8], bits[9], exp_b);
    check("tx_byte", bits[7:0], exp_b);
    check("tx_parity", bits[8], ~^exp_b);
    check("tx_stop", bits[9], 1'b1);
  endtask

  // Mouse side of a device-to-host byte, optionally with a corrupted parity bit.
  task automatic dev_send(input logic [7:0] b, input bit bad_par);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    $display("device sends byte=%02h bad_parity=%0d", b, bad_par);
    tick(HALF);
    for (int i = 0; i < 11; i++) begin
      dev_data_low = ~f[i];
      tick(QTR);
      dev_clk_low = 1'b1;
      tick(HALF);
      dev_clk_low = 1'b0;
      tick(HALF - QTR);
    end
    dev_data_low = 1'b0;
  endtask

  task automatic run_compliant();
    tx_q.push_back(8'hFF);
    host_frame();
    dev_send(8'hFA, 1'b0);
    dev_send(8'hAA, 1'b0);
    dev_send(8'h00, 1'b0);
`ifdef SAMPLE_RATE_EN
    tx_q.push_back(8'hF3);
    host_frame();
    dev_send(8'hFA, 1'b0);
    tx_q.push_back(8'h64);
    host_frame();
    dev_send(8'hFA, 1'b0);
`endif
    tx_q.push_back(8'hF4);
    host_frame();
    dev_send(8'hFA, 1'b0);
    tick(10);
  endtask

  initial begin
    int n;

    // Reset state
    tick(3);
    check("reset_state_dbg", state_dbg, 4'd0);
    check_status("reset", 1'b0, 1'b0, 1'b0, 2'd0);
    reset = 1'b0;
    tick(2);

    // Compliant mouse from IDLE
    $display("step: compliant sequence");
    pulse_start();
    run_compliant();
    check_status("stream1", 1'b1, 1'b1, 1'b0, 2'd0);

    // Restart from STREAM; mouse NACKs the reset, second attempt is clean
    $display("step: start during STREAM, NACK then retry");
    start = 1'b1;
    #1;
    check("enable_drop_same_cycle", enable_send, 1'b0);
    @(negedge clk);
    start = 1'b0;
    tx_q.push_back(8'hFF);
    host_frame();
    dev_send(8'hFE, 1'b0);
    check("nack_retry_count", retry_count, 2'd1);
    check("nack_not_done", init_done, 1'b0);
    run_compliant();
    check_status("stream_nack", 1'b1, 1'b1, 1'b0, 2'd1);

    // BAT byte with bad parity is retried
    $display("step: BAT bad parity then retry");
    pulse_start();
    tx_q.push_back(8'hFF);
    host_frame();
    dev_send(8'hFA, 1'b0);
    dev_send(8'hAA, 1'b1);
    check("bat_retry_count", retry_count, 2'd1);
    run_compliant();
    check_status("stream_bat", 1'b1, 1'b1, 1'b0, 2'd1);

    // Silent mouse: four timed-out attempts then ERROR
    $display("step: silent mouse");
    pulse_start();
    n = 0;
    while (init_error !== 1'b1 && n < 6 * RT) begin tick(1); n++; end
    $display("silent mouse reached error after %0d cycles", n);
    check("silent_latency", n, 4 * RT);
    check_status("error", 1'b0, 1'b0, 1'b1, 2'd3);

    // Restart from ERROR, then reset while the host frame is under way
    $display("step: reset during host transmit");
    pulse_start();
    check("err_cleared", init_error, 1'b0);
    check("retry_cleared", retry_count, 2'd0);
    n = 0;
    while (ps2_clk_oe !== 1'b1 && n < RT) begin tick(1); n++; end
    n = 0;
    while (ps2_clk_oe === 1'b1 && n < RT) begin tick(1); n++; end
    check("pre_reset_data_oe", ps2_data_oe, 1'b1);
    reset = 1'b1;
    tick(1);
    check("reset_mid_state_dbg", state_dbg, 4'd0);
    check_status("reset_mid", 1'b0, 1'b0, 1'b0, 2'd0);
    reset = 1'b0;
    tick(2);

    // Clean bring-up after the reset
    $display("step: compliant sequence after reset");
    pulse_start();
    run_compliant();
    check_status("stream_final", 1'b1, 1'b1, 1'b0, 2'd0);
    check("sb_drained", tx_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
